// File: rtl/opc5ls_bus_responder.sv
// Memory-side responder for the OPC5LS CPU bus: word RAM plus an I/O window
// holding a byte transmit FIFO, a receive holding register and a reload timer.
module opc5ls_bus_responder #(
  parameter int          RAM_AWIDTH    = 11,
  parameter logic [15:0] IO_BASE       = 16'hFE00,
  parameter int          TX_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_dout,
  input  logic        cpu_rnw,
  output logic [15:0] cpu_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe
);

  localparam int RAM_WORDS = 1 << RAM_AWIDTH;
  localparam int TX_DEPTH_N = 1 << TX_DEPTH_LOG2;

  logic [15:0] ram [RAM_WORDS];

  logic [7:0]               tx_mem [TX_DEPTH_N];
  logic [TX_DEPTH_LOG2-1:0] tx_rd_ptr, tx_wr_ptr;
  logic [TX_DEPTH_LOG2:0]   tx_count;
  logic                     tx_overflow;

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_overrun;

  logic [15:0] timer_reload, timer_count;
  logic        timer_expired;

  logic        ram_sel, io_sel;
  logic [3:0]  io_offset;
  logic        io_write, io_read;
  logic        tx_full, tx_empty, tx_push, tx_pop, tx_accept;
  logic        rx_pop, status_write;

  assign ram_sel   = (cpu_address >> RAM_AWIDTH) == 16'd0;
  assign io_sel    = cpu_address[15:4] == IO_BASE[15:4];
  assign io_offset = cpu_address[3:0];
  assign io_write  = io_sel && !cpu_rnw;
  assign io_read   = io_sel && cpu_rnw;

  assign tx_full   = tx_count[TX_DEPTH_LOG2];
  assign tx_empty  = tx_count == '0;
  assign tx_valid  = !tx_empty;
  assign tx_data   = tx_mem[tx_rd_ptr];
  assign tx_push   = io_write && io_offset == 4'd0;
  assign tx_pop    = tx_valid && tx_ready;
  // A full FIFO still takes a byte if the head leaves in the same cycle.
  assign tx_accept = tx_push && (!tx_full || tx_pop);

  assign rx_pop       = io_read && io_offset == 4'd2;
  assign status_write = io_write && io_offset == 4'd1;

  always_comb begin
    cpu_din = 16'd0;
    if (ram_sel) begin
      cpu_din = ram[cpu_address[RAM_AWIDTH-1:0]];
    end else if (io_sel) begin
      case (io_offset)
        4'd1: cpu_din = {10'd0, rx_overrun, timer_expired, tx_overflow,
                         rx_valid, tx_empty, tx_full};
        4'd2: cpu_din = {8'd0, rx_byte};
        4'd3: cpu_din = timer_reload;
        4'd4: cpu_din = timer_count;
        default: cpu_din = 16'd0;
      endcase
    end
  end

  // RAM has no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (!cpu_rnw && ram_sel) begin
      ram[cpu_address[RAM_AWIDTH-1:0]] <= cpu_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TX_DEPTH_N; i++) tx_mem[i] <= 8'd0;
      tx_rd_ptr   <= '0;
      tx_wr_ptr   <= '0;
      tx_count    <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_accept) begin
        tx_mem[tx_wr_ptr] <= cpu_dout[7:0];
        tx_wr_ptr         <= tx_wr_ptr + 1'b1;
      end
      if (tx_pop) tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (tx_accept && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (tx_pop && !tx_accept) tx_count <= tx_count - 1'b1;
      if (tx_push && !tx_accept)        tx_overflow <= 1'b1;
      else if (status_write && cpu_dout[3]) tx_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_byte    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_strobe) begin
        rx_byte  <= rx_data;
        rx_valid <= 1'b1;
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end
      if (rx_strobe && rx_valid && !rx_pop)  rx_overrun <= 1'b1;
      else if (status_write && cpu_dout[5])  rx_overrun <= 1'b0;
    end
  end

  // A CPU load of the count overrides both decrement and reload that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reload  <= 16'd0;
      timer_count   <= 16'd0;
      timer_expired <= 1'b0;
    end else begin
      if (io_write && io_offset == 4'd3) timer_reload <= cpu_dout;
      if (io_write && io_offset == 4'd4) begin
        timer_count <= cpu_dout;
        if (status_write && cpu_dout[4]) timer_expired <= 1'b0;
      end else if (timer_reload != 16'd0 && timer_count == 16'd0) begin
        timer_count   <= timer_reload;
        timer_expired <= 1'b1;
      end else begin
        if (timer_reload != 16'd0) timer_count <= timer_count - 16'd1;
        if (status_write && cpu_dout[4]) timer_expired <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_opc5ls_bus_responder.sv
// Directed bench for opc5ls_bus_responder; TX bytes are checked against a
// scoreboard queue filled as bytes are pushed.
module tb_opc5ls_bus_responder;

  localparam logic [15:0] IO   = 16'hFE00;
  localparam logic [15:0] IDLE = 16'h8000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_address, cpu_dout, cpu_din;
  logic        cpu_rnw;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_strobe;

  int total = 0;
  int bad   = 0;
  logic [7:0] txq [$];
  logic [7:0] exp_byte;

  opc5ls_bus_responder dut (
    .clk(clk), .reset(reset), .cpu_address(cpu_address), .cpu_dout(cpu_dout),
    .cpu_rnw(cpu_rnw), .cpu_din(cpu_din), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_strobe(rx_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
    cpu_address = addr;
    cpu_dout    = data;
    cpu_rnw     = 1'b0;
    tick();
    cpu_rnw     = 1'b1;
    cpu_address = IDLE;
  endtask

  // Samples the combinational read data, then lets the read cycle complete.
  task automatic cpu_read(input logic [15:0] addr, input string tag, input logic [15:0] exp);
    cpu_address = addr;
    cpu_rnw     = 1'b1;
    #1;
    check(tag, cpu_din, exp);
    tick();
    cpu_address = IDLE;
  endtask

  // Looks at a register within the current cycle without advancing the clock.
  task automatic peek(input logic [15:0] addr, input string tag, input logic [15:0] exp);
    cpu_address = addr;
    cpu_rnw     = 1'b1;
    #1;
    check(tag, cpu_din, exp);
    cpu_address = IDLE;
  endtask

  task automatic push_tx(input logic [7:0] b, input bit expect_accept);
    if (expect_accept) txq.push_back(b);
    cpu_write(IO, {8'h00, b});
  endtask

  task automatic drain_tx();
    for (int i = 0; i < 12 && txq.size() != 0; i++) begin
      if (tx_valid) begin
        exp_byte = txq.pop_front();
        check("tx_byte", {8'h00, tx_data}, {8'h00, exp_byte});
      end
      tick();
    end
    check("tx_drain_left", 16'(txq.size()), 16'd0);
    check("tx_valid_after_drain", {15'd0, tx_valid}, 16'd0);
  endtask

  initial begin
    reset = 1'b1; cpu_address = IDLE; cpu_dout = 16'd0; cpu_rnw = 1'b1;
    tx_ready = 1'b0; rx_data = 8'd0; rx_strobe = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    check("reset_tx_valid", {15'd0, tx_valid}, 16'd0);
    check("reset_tx_data", {8'd0, tx_data}, 16'd0);
    peek(IO + 16'd1, "reset_status", 16'h0002);
    peek(IO + 16'd2, "reset_rx_data", 16'h0000);
    peek(IO + 16'd3, "reset_reload", 16'h0000);
    peek(IO + 16'd4, "reset_count", 16'h0000);

    cpu_write(16'h0005, 16'h1234);
    cpu_read(16'h0005, "ram_5", 16'h1234);
    cpu_write(16'h07FF, 16'hBEEF);
    cpu_write(16'h0000, 16'hAAAA);
    cpu_write(16'h0800, 16'h5555);
    cpu_read(16'h07FF, "ram_top", 16'hBEEF);
    cpu_read(16'h0000, "ram_0_no_alias", 16'hAAAA);
    cpu_read(16'h0800, "above_ram", 16'h0000);
    cpu_read(16'h4000, "unmapped", 16'h0000);
    cpu_write(IO + 16'd7, 16'hFFFF);
    cpu_read(IO + 16'd7, "io_unused", 16'h0000);
    cpu_read(IO, "tx_data_read", 16'h0000);

    tx_ready = 1'b0;
    for (int b = 8'h41; b <= 8'h44; b++) push_tx(8'(b), 1'b1);
    push_tx(8'h45, 1'b0);
    peek(IO + 16'd1, "status_full_ovf", 16'h0009);
    check("tx_head", {8'd0, tx_data}, 16'h0041);
    tick(); tick();
    check("tx_head_stable", {8'd0, tx_data}, 16'h0041);
    tx_ready = 1'b1;
    drain_tx();
    peek(IO + 16'd1, "status_ovf_sticky", 16'h000A);
    tx_ready = 1'b0;
    cpu_write(IO + 16'd1, 16'h0008);
    peek(IO + 16'd1, "status_ovf_clear", 16'h0002);

    for (int b = 8'h61; b <= 8'h64; b++) push_tx(8'(b), 1'b1);
    tx_ready = 1'b1;
    cpu_address = IO; cpu_dout = 16'h0055; cpu_rnw = 1'b0;
    #1;
    exp_byte = txq.pop_front();
    check("tx_byte_on_full_push", {8'd0, tx_data}, {8'd0, exp_byte});
    txq.push_back(8'h55);
    tick();
    cpu_rnw = 1'b1; cpu_address = IDLE;
    peek(IO + 16'd1, "status_full_no_ovf", 16'h0001);
    drain_tx();
    tx_ready = 1'b0;
    peek(IO + 16'd1, "status_after_push_pop", 16'h0002);

    rx_data = 8'h7E; rx_strobe = 1'b1; tick(); rx_strobe = 1'b0;
    peek(IO + 16'd1, "status_rx_valid", 16'h0006);
    cpu_read(IO + 16'd2, "rx_read", 16'h007E);
    peek(IO + 16'd1, "status_rx_popped", 16'h0002);
    rx_data = 8'h11; rx_strobe = 1'b1; tick();
    rx_data = 8'h22; tick(); rx_strobe = 1'b0;
    peek(IO + 16'd1, "status_overrun", 16'h0026);
    cpu_read(IO + 16'd2, "rx_second_byte", 16'h0022);
    peek(IO + 16'd1, "status_overrun_sticky", 16'h0022);
    cpu_write(IO + 16'd1, 16'h0020);
    peek(IO + 16'd1, "status_overrun_clear", 16'h0002);
    rx_data = 8'h33; rx_strobe = 1'b1; tick();
    rx_data = 8'h44;
    cpu_read(IO + 16'd2, "rx_pop_with_strobe", 16'h0033);
    rx_strobe = 1'b0;
    peek(IO + 16'd1, "status_no_overrun", 16'h0006);
    cpu_read(IO + 16'd2, "rx_new_byte", 16'h0044);

    cpu_write(IO + 16'd3, 16'h0003);
    peek(IO + 16'd3, "reload_readback", 16'h0003);
    begin
      logic [15:0] seq [6] = '{16'd0, 16'd3, 16'd2, 16'd1, 16'd0, 16'd3};
      for (int i = 0; i < 6; i++) begin
        peek(IO + 16'd4, "timer_count", seq[i]);
        peek(IO + 16'd1, "timer_expired", (i == 0) ? 16'h0002 : 16'h0012);
        tick();
      end
    end
    cpu_write(IO + 16'd1, 16'h0010);
    peek(IO + 16'd4, "count_after_clear", 16'd1);
    peek(IO + 16'd1, "expired_cleared", 16'h0002);
    tick();
    peek(IO + 16'd4, "count_zero", 16'd0);
    peek(IO + 16'd1, "expired_still_clear", 16'h0002);
    tick();
    peek(IO + 16'd4, "count_reloaded", 16'd3);
    peek(IO + 16'd1, "expired_again", 16'h0012);
    cpu_write(IO + 16'd4, 16'h0100);
    peek(IO + 16'd4, "count_loaded", 16'h0100);
    tick();
    peek(IO + 16'd4, "count_dec_after_load", 16'h00FF);

    push_tx(8'h71, 1'b1);
    push_tx(8'h72, 1'b1);
    txq.delete();
    reset = 1'b1;
    tick();
    check("midreset_tx_valid", {15'd0, tx_valid}, 16'd0);
    check("midreset_tx_data", {8'd0, tx_data}, 16'd0);
    peek(IO + 16'd1, "midreset_status", 16'h0002);
    peek(IO + 16'd4, "midreset_count", 16'h0000);
    reset = 1'b0;
    tick();
    peek(IO + 16'd4, "count_held_after_reset", 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
